// File: rtl/mp_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mp_add_sequencer_pkg
// Purpose : Shared definitions for the multi-precision adder sequencer:
//           default adder word width, FSM state encoding and a helper that
//           sizes the word index counter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mp_add_sequencer_pkg;

    // Word width of the ripple-carry datapath.
    localparam int ADD_WIDTH = 32;

    // Sequencer states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index counter width: max(1, clog2(words)) so WORDS==1 still gets a bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripplecarryadder.sv
`default_nettype none
// ============================================================================
// Module  : ripplecarryadder
// Purpose : WIDTH-bit unsigned ripple-carry adder built from full-adder cells.
// Ports   : a, b   in  WIDTH  addends
//           cin    in  1      carry in
//           sum    out WIDTH  a + b + cin (low WIDTH bits)
//           carry  out 1      carry out of the top bit
// Revision: 1.0 - initial release
// ============================================================================
module ripplecarryadder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry = c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/mp_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mp_add_sequencer
// Purpose : Multi-precision adder. Accepts two WORDS*WIDTH-bit operands and a
//           carry-in, then adds them one WIDTH-bit word per cycle (LSW first)
//           through a single ripple-carry adder, chaining carries between
//           words, and presents the assembled sum and final carry.
// Ports   : clk        in   rising-edge clock
//           rst        in   asynchronous active-high reset
//           in_valid   in   operands/cin valid
//           in_ready   out  sequencer idle and able to accept
//           op_a/op_b  in   WORDS*WIDTH operands, word i at [i*WIDTH +: WIDTH]
//           cin        in   carry into word 0
//           out_valid  out  sum/cout valid
//           out_ready  in   consumer accepts the result
//           sum        out  (op_a + op_b + cin) mod 2^(WORDS*WIDTH)
//           cout       out  carry out of the most significant word
// Revision: 1.0 - initial release
// ============================================================================
module mp_add_sequencer
    import mp_add_sequencer_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] op_a,
    input  logic [WORDS*WIDTH-1:0] op_b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WIDTH-1:0] sum,
    output logic                   cout
);

    localparam int               IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic                     carry_reg;
    logic [WORDS*WIDTH-1:0]   a_reg;
    logic [WORDS*WIDTH-1:0]   b_reg;

    logic [WIDTH-1:0]         word_a;
    logic [WIDTH-1:0]         word_b;
    logic [WIDTH-1:0]         word_sum;
    logic                     word_carry;

    // Select the current word of each captured operand.
    assign word_a = a_reg[idx*WIDTH +: WIDTH];
    assign word_b = b_reg[idx*WIDTH +: WIDTH];

    ripplecarryadder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (word_a),
        .b     (word_b),
        .cin   (carry_reg),
        .sum   (word_sum),
        .carry (word_carry)
    );

    // Single-process FSM; in_ready/out_valid are registered alongside the
    // state so they always equal (state==IDLE) / (state==DONE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        carry_reg <= cin;
                        idx       <= '0;
                        state     <= ST_RUN;
                        in_ready  <= 1'b0;
                    end
                end

                ST_RUN: begin
                    sum[idx*WIDTH +: WIDTH] <= word_sum;
                    carry_reg               <= word_carry;
                    if (idx == LAST_IDX) begin
                        cout      <= word_carry;
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end

                ST_DONE: begin
                    // Return to IDLE only; a new operand is taken on a later edge.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
